multi_digit_scanner: RTL and testbench

MULTI_DIGIT_SCANNER -- requirements
Module: multi_digit_scanner

---
 rtl/seg_pkg.sv | 27 ++
 rtl/hex_to_seg.sv | 11 +
 rtl/multi_digit_scanner.sv | 133 +++++++++++++
 tb/tb_multi_digit_scanner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment bit order, hex glyph table and scan phase type
package seg_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    // Active-high glyphs, bit SEG_x set means segment x lit; index is the nibble.
    localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-high 7-segment glyph
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0]       i_hex,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = HEX_GLYPH[i_hex];

endmodule

// File: rtl/multi_digit_scanner.sv
// rtl/multi_digit_scanner.sv - time-multiplexed hex display scanner with per-slot blanking
module multi_digit_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 48000,
    parameter int BLANK_CYCLES = 480,
    parameter int ACTIVE_LOW   = 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [SEG_W-1:0]        seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int              CW        = $clog2(SLOT_CYCLES);
    localparam int              IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]   SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW:0]     BLANK_LEN = (CW + 1)'(BLANK_CYCLES);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic            POL       = (ACTIVE_LOW != 0);

    logic [CW-1:0]         r_slot_cnt;
    logic [IW-1:0]         r_idx;
    logic [3:0]            r_nib;
    logic                  r_dp;
    logic                  r_en;
    logic                  r_fresh;
    logic [SEG_W-1:0]      r_seg;
    logic                  r_seg_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_tick;

    logic                  w_wrap;
    logic [IW-1:0]         w_next_idx;
    logic [3:0]            w_in_nib;
    logic                  w_in_dp;
    logic                  w_in_en;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_dp;
    logic                  w_cur_en;
    phase_t                w_phase;
    logic                  w_lit;
    logic [SEG_W-1:0]      w_glyph;
    logic [NUM_DIGITS-1:0] w_an_act;

    assign w_wrap = (r_slot_cnt == SLOT_LAST);

    always_comb begin
        w_next_idx = r_idx;
        if (w_wrap) begin
            w_next_idx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    always_comb begin
        w_in_nib = digits[3:0];
        w_in_dp  = dp[0];
        w_in_en  = digit_en[0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (w_next_idx == IW'(i)) begin
                w_in_nib = digits[4*i +: 4];
                w_in_dp  = dp[i];
                w_in_en  = digit_en[i];
            end
        end
    end

    // The first slot after reset latches at its own end, so it drives from the live inputs.
    assign w_cur_nib = r_fresh ? w_in_nib : r_nib;
    assign w_cur_dp  = r_fresh ? w_in_dp  : r_dp;
    assign w_cur_en  = r_fresh ? w_in_en  : r_en;

    assign w_phase = ({1'b0, r_slot_cnt} < BLANK_LEN) ? BLANK : DRIVE;
    assign w_lit   = (w_phase == DRIVE) && w_cur_en;

    hex_to_seg u_hex_to_seg (
        .i_hex (w_cur_nib),
        .o_seg (w_glyph)
    );

    always_comb begin
        w_an_act = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_act[i] = w_lit && (r_idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
            r_fresh    <= 1'b1;
            r_nib      <= '0;
            r_dp       <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            r_slot_cnt <= w_wrap ? '0 : r_slot_cnt + 1'b1;
            r_idx      <= w_next_idx;
            r_fresh    <= 1'b0;
            if (w_wrap || r_fresh) begin
                r_nib <= w_in_nib;
                r_dp  <= w_in_dp;
                r_en  <= w_in_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an         <= {NUM_DIGITS{POL}};
            r_seg        <= {SEG_W{POL}};
            r_seg_dp     <= POL;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_act ^ {NUM_DIGITS{POL}};
            r_seg        <= (w_lit ? w_glyph : '0) ^ {SEG_W{POL}};
            r_seg_dp     <= (w_lit & w_cur_dp) ^ POL;
            r_frame_tick <= (r_idx == '0) && (r_slot_cnt == '0);
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign seg_dp     = r_seg_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_multi_digit_scanner.sv
// tb/tb_multi_digit_scanner.sv - self-checking bench for multi_digit_scanner
module tb_multi_digit_scanner;

    localparam int N    = 4;
    localparam int SLOT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame_tick;

    logic [3:0]  dig_b;
    logic        en_b;
    logic        dp_b;
    logic [6:0]  seg_b;
    logic        seg_dp_b;
    logic [0:0]  an_b;
    logic        ft_b;

    int          checks;
    int          errors;
    int          k;
    logic [3:0]  sa_nib;
    logic        sa_en;
    logic        sa_dp;
    logic [3:0]  sb_nib;
    logic        sb_en;
    logic        sb_dp;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    multi_digit_scanner #(
        .NUM_DIGITS   (4),
        .SLOT_CYCLES  (8),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp         (dp),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    multi_digit_scanner #(
        .NUM_DIGITS   (1),
        .SLOT_CYCLES  (8),
        .BLANK_CYCLES (0),
        .ACTIVE_LOW   (0)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .digits     (dig_b),
        .digit_en   (en_b),
        .dp         (dp_b),
        .seg        (seg_b),
        .seg_dp     (seg_dp_b),
        .an         (an_b),
        .frame_tick (ft_b)
    );

    function automatic logic [6:0] glyph(input logic [3:0] h);
        string      s;
        logic [6:0] g;
        g = '0;
        case (h)
            4'h0: s = "abcdef";
            4'h1: s = "bc";
            4'h2: s = "abdeg";
            4'h3: s = "abcdg";
            4'h4: s = "bcfg";
            4'h5: s = "acdfg";
            4'h6: s = "acdefg";
            4'h7: s = "abc";
            4'h8: s = "abcdefg";
            4'h9: s = "abcdfg";
            4'hA: s = "abcefg";
            4'hB: s = "cdefg";
            4'hC: s = "adef";
            4'hD: s = "bcdeg";
            4'hE: s = "adefg";
            default: s = "aefg";
        endcase
        for (int i = 0; i < s.len(); i++) begin
            g[int'(s[i]) - 97] = 1'b1;
        end
        return g;
    endfunction

    // Expected outputs after edge kk (kk >= 1) counted from reset release.
    function automatic void model(input int n, input int blank, input int al, input int kk,
                                  input logic [3:0] nib, input logic en, input logic dpv,
                                  output logic [7:0] an_e, output logic [6:0] seg_e,
                                  output logic dp_e, output logic ft_e);
        int   pos;
        int   dig;
        logic lit;
        pos   = (kk - 1) % SLOT;
        dig   = ((kk - 1) / SLOT) % n;
        lit   = (pos >= blank) && en;
        an_e  = lit ? 8'(1 << dig) : 8'h00;
        seg_e = lit ? glyph(nib) : 7'h00;
        dp_e  = lit && dpv;
        ft_e  = ((kk - 1) % (n * SLOT)) == 0;
        if (al != 0) begin
            an_e  = ~an_e;
            seg_e = ~seg_e;
            dp_e  = ~dp_e;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    task automatic snap_a(input int d);
        sa_nib = digits[4*d +: 4];
        sa_en  = digit_en[d];
        sa_dp  = dp[d];
    endtask

    task automatic snap_b();
        sb_nib = dig_b;
        sb_en  = en_b;
        sb_dp  = dp_b;
    endtask

    task automatic step();
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        logic       ef;
        logic [7:0] eab;
        logic [6:0] esb;
        logic       edb;
        logic       efb;
        @(posedge clk);
        if (reset) begin
            k = 0;
            #1;
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_seg_dp", 32'(seg_dp), 32'h1);
            chk("rst_frame_tick", 32'(frame_tick), 32'h0);
            chk("rst_b_an", 32'(an_b), 32'h0);
            chk("rst_b_seg", 32'(seg_b), 32'h0);
            chk("rst_b_frame_tick", 32'(ft_b), 32'h0);
        end else begin
            k++;
            if (k == 1) begin
                snap_a(0);
                snap_b();
            end
            model(N, 2, 1, k, sa_nib, sa_en, sa_dp, ea, es, ed, ef);
            model(1, 0, 0, k, sb_nib, sb_en, sb_dp, eab, esb, edb, efb);
            if (k % SLOT == 0) begin
                snap_a((k / SLOT) % N);
                snap_b();
            end
            #1;
            chk("an", 32'(an), 32'(ea[3:0]));
            chk("seg", 32'(seg), 32'(es));
            chk("seg_dp", 32'(seg_dp), 32'(ed));
            chk("frame_tick", 32'(frame_tick), 32'(ef));
            chk("b_an", 32'(an_b), 32'(eab[0]));
            chk("b_seg", 32'(seg_b), 32'(esb));
            chk("b_seg_dp", 32'(seg_dp_b), 32'(edb));
            chk("b_frame_tick", 32'(ft_b), 32'(efb));
        end
    endtask

    task automatic step_until(input int m, input int t, input int min_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((n < min_n || (k % m) != t) && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL sync_timeout actual=%0d required=%0d", k % m, t);
        end
    endtask

    initial begin
        int ticks_a;
        int ticks_b;
        int consec;
        int lit_cnt;
        logic prev_ft;

        tbl[0] = '{4'h1, 7'b1111001};
        tbl[1] = '{4'h8, 7'b0000000};
        tbl[2] = '{4'h0, 7'b1000000};
        tbl[3] = '{4'hF, 7'b0001110};
        tbl[4] = '{4'hA, 7'b0001000};
        tbl[5] = '{4'h4, 7'b0011001};
        tbl[6] = '{4'hB, 7'b0000011};
        tbl[7] = '{4'hD, 7'b0100001};

        checks   = 0;
        errors   = 0;
        k        = 0;
        reset    = 1'b1;
        digits   = 16'h4321;
        digit_en = 4'hF;
        dp       = 4'h0;
        dig_b    = 4'h5;
        en_b     = 1'b1;
        dp_b     = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // Basic scan: two blank cycles, then digit 0 shows "1".
        step();
        step();
        chk("scan_blank_an", 32'(an), 32'hF);
        step();
        chk("scan_d0_an", 32'(an), 32'b1110);
        chk("scan_d0_seg", 32'(seg), 32'b1111001);
        chk("b_an_on", 32'(an_b), 32'h1);
        chk("b_seg_dp_on", 32'(seg_dp_b), 32'h1);
        repeat (61) step();

        for (int i = 0; i < 8; i++) begin
            digits = {4{tbl[i].nib}};
            step_until(SLOT, 5, SLOT);
            chk($sformatf("glyph_%h", tbl[i].nib), 32'(seg), 32'(tbl[i].seg));
        end

        // Input change mid-slot must not disturb the slot in progress.
        digits = 16'h4321;
        step_until(N * SLOT, 4, N * SLOT);
        digits[3:0] = 4'h8;
        step_until(N * SLOT, 6, 1);
        chk("hold_mid_slot_seg", 32'(seg), 32'b1111001);
        step_until(N * SLOT, 3, 1);
        chk("new_slot_seg", 32'(seg), 32'b0000000);

        // Disabled digit keeps its slot dark; frame period unchanged.
        digit_en = 4'b1011;
        step_until(N * SLOT, 0, 1);
        lit_cnt = 0;
        ticks_a = 0;
        for (int i = 0; i < N * SLOT; i++) begin
            step();
            if (an != 4'hF) lit_cnt++;
            if (frame_tick) ticks_a++;
        end
        chk("disabled_lit_cycles", 32'(lit_cnt), 32'd18);
        chk("disabled_frame_ticks", 32'(ticks_a), 32'd1);

        digit_en = 4'hF;
        ticks_a  = 0;
        ticks_b  = 0;
        consec   = 0;
        prev_ft  = 1'b0;
        for (int i = 0; i < 320; i++) begin
            step();
            if (frame_tick) ticks_a++;
            if (ft_b) ticks_b++;
            if (frame_tick && prev_ft) consec++;
            prev_ft = frame_tick;
        end
        chk("frame_ticks_320", 32'(ticks_a), 32'd10);
        chk("b_frame_ticks_320", 32'(ticks_b), 32'd40);
        chk("frame_tick_consecutive", 32'(consec), 32'd0);

        // Mid-DRIVE reset on digit 2.
        step_until(N * SLOT, 20, 1);
        reset = 1'b1;
        step();
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        repeat (3) step();
        chk("restart_d0_an", 32'(an), 32'b1110);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) digits   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 7) == 0) dp       = 4'($urandom);
            if ($urandom_range(0, 5) == 0) dig_b    = 4'($urandom);
            if ($urandom_range(0, 9) == 0) en_b     = 1'($urandom);
            if ($urandom_range(0, 9) == 0) dp_b     = 1'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
